// File: rtl/player_flash_ctrl_if.sv
// Event inputs and blink outputs between game logic and one player's flash sequencer.
interface player_flash_ctrl_if;
  logic startOfFrame;
  logic pause;
  logic player_hit;
  logic powerup_taken;
  logic invert_player;
  logic invincible;
  logic busy;

  modport master (
    output startOfFrame, pause, player_hit, powerup_taken,
    input  invert_player, invincible, busy
  );

  modport slave (
    input  startOfFrame, pause, player_hit, powerup_taken,
    output invert_player, invincible, busy
  );
endinterface

// File: rtl/player_flash_ctrl.sv
// Frame-counted blink sequencer: long invincible blink on a hit, short fast blink on a pickup.
module player_flash_ctrl #(
  parameter int HIT_FRAMES    = 120,
  parameter int HIT_TOGGLE    = 8,
  parameter int PICKUP_FRAMES = 30,
  parameter int PICKUP_TOGGLE = 3
) (
  input logic             clk,
  input logic             reset,
  player_flash_ctrl_if.slave pf
);
  localparam int MAX_FRAMES = (HIT_FRAMES > PICKUP_FRAMES) ? HIT_FRAMES : PICKUP_FRAMES;
  localparam int MAX_TOGGLE = (HIT_TOGGLE > PICKUP_TOGGLE) ? HIT_TOGGLE : PICKUP_TOGGLE;
  localparam int REM_W      = $clog2(MAX_FRAMES + 1);
  localparam int TOG_W      = (MAX_TOGGLE > 1) ? $clog2(MAX_TOGGLE) : 1;

  localparam logic [REM_W-1:0] HIT_LOAD    = REM_W'(HIT_FRAMES);
  localparam logic [REM_W-1:0] PICKUP_LOAD = REM_W'(PICKUP_FRAMES);
  localparam logic [TOG_W-1:0] HIT_LAST    = TOG_W'(HIT_TOGGLE - 1);
  localparam logic [TOG_W-1:0] PICKUP_LAST = TOG_W'(PICKUP_TOGGLE - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HIT_FLASH    = 2'd1,
    PICKUP_FLASH = 2'd2
  } state_t;

  state_t           state_p0, state_nx;
  logic [REM_W-1:0] remain_p0, remain_nx;
  logic [TOG_W-1:0] tog_p0, tog_nx;
  logic             inv_p0, inv_nx;
  logic             invinc_p0;
  logic             busy_p0;

  logic             frame_tick;
  logic [TOG_W-1:0] tog_last;

  assign frame_tick = pf.startOfFrame && !pf.pause;
  assign tog_last   = (state_p0 == HIT_FLASH) ? HIT_LAST : PICKUP_LAST;

  always_comb begin
    state_nx  = state_p0;
    remain_nx = remain_p0;
    tog_nx    = tog_p0;
    inv_nx    = inv_p0;
    unique case (state_p0)
      IDLE: begin
        if (pf.player_hit) begin
          state_nx  = HIT_FLASH;
          remain_nx = HIT_LOAD;
          tog_nx    = '0;
          inv_nx    = 1'b1;
        end else if (pf.powerup_taken) begin
          state_nx  = PICKUP_FLASH;
          remain_nx = PICKUP_LOAD;
          tog_nx    = '0;
          inv_nx    = 1'b1;
        end
      end
      HIT_FLASH, PICKUP_FLASH: begin
        // Pickup flash can be preempted or restarted; an event always outranks the frame tick.
        if (state_p0 == PICKUP_FLASH && pf.player_hit) begin
          state_nx  = HIT_FLASH;
          remain_nx = HIT_LOAD;
          tog_nx    = '0;
          inv_nx    = 1'b1;
        end else if (state_p0 == PICKUP_FLASH && pf.powerup_taken) begin
          remain_nx = PICKUP_LOAD;
          tog_nx    = '0;
          inv_nx    = 1'b1;
        end else if (frame_tick) begin
          if (remain_p0 == REM_W'(1)) begin
            state_nx  = IDLE;
            remain_nx = '0;
            tog_nx    = '0;
            inv_nx    = 1'b0;
          end else begin
            remain_nx = remain_p0 - REM_W'(1);
            if (tog_p0 == tog_last) begin
              tog_nx = '0;
              inv_nx = ~inv_p0;
            end else begin
              tog_nx = tog_p0 + TOG_W'(1);
            end
          end
        end
      end
      default: begin
        state_nx  = IDLE;
        remain_nx = '0;
        tog_nx    = '0;
        inv_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= IDLE;
      remain_p0 <= '0;
      tog_p0    <= '0;
      inv_p0    <= 1'b0;
      invinc_p0 <= 1'b0;
      busy_p0   <= 1'b0;
    end else begin
      state_p0  <= state_nx;
      remain_p0 <= remain_nx;
      tog_p0    <= tog_nx;
      inv_p0    <= inv_nx;
      invinc_p0 <= (state_nx == HIT_FLASH);
      busy_p0   <= (state_nx != IDLE);
    end
  end

  assign pf.invert_player = inv_p0;
  assign pf.invincible    = invinc_p0;
  assign pf.busy          = busy_p0;
endmodule

// File: tb/tb_player_flash_ctrl.sv
// Directed bench for player_flash_ctrl with a queue of expected outputs per cycle.
module tb_player_flash_ctrl;
  logic clk = 1'b0;
  logic reset;

  player_flash_ctrl_if pf ();

  player_flash_ctrl #(
    .HIT_FRAMES(6), .HIT_TOGGLE(2), .PICKUP_FRAMES(4), .PICKUP_TOGGLE(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pf   (pf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  inv;
    logic  inc;
    logic  bsy;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input logic rst, input logic sof, input logic hit, input logic pick,
                     input logic pse, input logic e_inv, input logic e_inc, input logic e_bsy,
                     input string tag);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    pf.startOfFrame  = sof;
    pf.player_hit    = hit;
    pf.powerup_taken = pick;
    pf.pause         = pse;
    sb.push_back('{e_inv, e_inc, e_bsy, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (pf.invert_player === e.inv) else begin
      errors++;
      $error("FAIL %s invert_player got %b exp %b", e.tag, pf.invert_player, e.inv);
    end
    checks++;
    assert (pf.invincible === e.inc) else begin
      errors++;
      $error("FAIL %s invincible got %b exp %b", e.tag, pf.invincible, e.inc);
    end
    checks++;
    assert (pf.busy === e.bsy) else begin
      errors++;
      $error("FAIL %s busy got %b exp %b", e.tag, pf.busy, e.bsy);
    end
  endtask

  task automatic chk_remain(input int exp_r, input string tag);
    checks++;
    assert (int'(dut.remain_p0) === exp_r) else begin
      errors++;
      $error("FAIL %s remain got %0d exp %0d", tag, dut.remain_p0, exp_r);
    end
  endtask

  initial begin
    reset = 1'b1;
    pf.startOfFrame = 1'b0; pf.player_hit = 1'b0; pf.powerup_taken = 1'b0; pf.pause = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "sof_idle");

    // Hit from IDLE
    cyc(0, 0, 1, 0, 0, 1, 1, 1, "hit_entry");
    chk_remain(6, "hit_load");
    cyc(0, 0, 0, 0, 0, 1, 1, 1, "hit_hold");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "hit_sof1");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "hit_sof2");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "hit_sof3");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "hit_sof4");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "hit_sof5");
    chk_remain(1, "hit_last");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "hit_sof6_end");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "after_hit_sof");

    // Pickup from IDLE
    cyc(0, 0, 0, 1, 0, 1, 0, 1, "pick_entry");
    cyc(0, 1, 0, 0, 0, 0, 0, 1, "pick_sof1");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, "pick_sof2");
    cyc(0, 1, 0, 0, 0, 0, 0, 1, "pick_sof3");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "pick_sof4_end");

    // Simultaneous hit+pickup, then an ignored second hit
    cyc(0, 0, 1, 1, 0, 1, 1, 1, "both_entry");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "both_sof1");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "both_sof2");
    cyc(0, 0, 1, 0, 0, 0, 1, 1, "hit_ignored");
    chk_remain(4, "hit_ignored_rem");
    cyc(0, 0, 0, 1, 0, 0, 1, 1, "pick_ignored");
    chk_remain(4, "pick_ignored_rem");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "both_sof3");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "both_sof4");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "both_sof5");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "both_sof6_end");

    // Pickup preempted by hit, then pause mid-hit
    cyc(0, 0, 0, 1, 0, 1, 0, 1, "pre_pick");
    cyc(0, 1, 0, 0, 0, 0, 0, 1, "pre_sof1");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, "pre_sof2");
    cyc(0, 0, 1, 0, 0, 1, 1, 1, "preempt_hit");
    chk_remain(6, "preempt_rem");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "pz_sof1");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "pz_sof2");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1, 0, 1, 1, "paused_sof");
    chk_remain(4, "paused_rem");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "pz_sof3");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "pz_sof4");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "pz_sof5");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "pz_sof6_end");

    // Events coincident with SOF are not counted; events during pause are accepted
    cyc(0, 1, 0, 1, 0, 1, 0, 1, "pick_with_sof");
    chk_remain(4, "pick_sof_rem");
    cyc(0, 1, 0, 0, 0, 0, 0, 1, "restart_sof1");
    chk_remain(3, "restart_pre");
    cyc(0, 1, 0, 1, 0, 1, 0, 1, "pick_restart");
    chk_remain(4, "pick_restart_rem");
    cyc(0, 0, 1, 0, 1, 1, 1, 1, "hit_in_pause");
    chk_remain(6, "hit_pause_rem");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, "rst_sof1");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, "rst_sof2");

    // Reset mid-hit
    cyc(1, 1, 0, 0, 0, 0, 0, 0, "reset_mid");
    chk_remain(0, "reset_rem");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "post_reset_sof");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
